// File: rtl/spi_flash_responder.sv
// SPI mode 0 flash target model: answers RDID and RDSR, all inputs oversampled in clk.
// Define SPI_FLASH_RESP_READ_EN to add the READ (0x03) command with synthetic data.
module spi_flash_responder #(
    parameter logic [23:0] FLASH_ID   = 24'h20BA18,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_b_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic [7:0] last_cmd_o,
    output logic       cmd_strobe_o,
    output logic       busy_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_RDID   = 3'd2;
    localparam logic [2:0] S_RDSR   = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;
`ifdef SPI_FLASH_RESP_READ_EN
    localparam logic [2:0] S_ADDR   = 3'd5;
    localparam logic [2:0] S_READ   = 3'd6;
`endif

    logic [2:0]  state;
    logic [2:0]  sclk_s;
    logic [1:0]  mosi_s;
    logic [1:0]  cs_s;
    logic        cs_d;
    logic [4:0]  bit_cnt;
    logic [7:0]  opcode;
    logic [31:0] shift_out;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0] op_next;

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    // Edge detects on cs use a delayed copy so a cs held low through reset is not seen as a fall
    assign cs_rise   = cs_s[1] & ~cs_d;
    assign cs_fall   = ~cs_s[1] & cs_d;
    assign op_next   = {opcode[6:0], mosi_s[1]};
    assign busy_o    = (state != S_IDLE);

`ifdef SPI_FLASH_RESP_READ_EN
    logic [23:0] addr;
    logic [23:0] addr_next;
    logic [23:0] addr_inc;
    assign addr_next = {addr[22:0], mosi_s[1]};
    assign addr_inc  = addr + 24'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sclk_s       <= '0;
            mosi_s       <= '0;
            cs_s         <= '0;
            cs_d         <= 1'b0;
            bit_cnt      <= '0;
            opcode       <= '0;
            shift_out    <= '0;
            miso_o       <= 1'b0;
            miso_oe_o    <= 1'b0;
            last_cmd_o   <= '0;
            cmd_strobe_o <= 1'b0;
`ifdef SPI_FLASH_RESP_READ_EN
            addr         <= '0;
`endif
        end else begin
            sclk_s       <= {sclk_s[1:0], sclk_i};
            mosi_s       <= {mosi_s[0], mosi_i};
            cs_s         <= {cs_s[0], cs_b_i};
            cs_d         <= cs_s[1];
            cmd_strobe_o <= 1'b0;
            if (cs_rise) begin
                // deselect beats any same-cycle sclk edge
                state     <= S_IDLE;
                miso_oe_o <= 1'b0;
                bit_cnt   <= '0;
                opcode    <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sclk_rise) begin
                            opcode  <= op_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                last_cmd_o   <= op_next;
                                cmd_strobe_o <= 1'b1;
                                bit_cnt      <= '0;
                                case (op_next)
                                    8'h9F: begin
                                        shift_out <= {FLASH_ID, 8'h00};
                                        state     <= S_RDID;
                                    end
                                    8'h05: begin
                                        shift_out <= {STATUS_VAL, 24'h0};
                                        state     <= S_RDSR;
                                    end
`ifdef SPI_FLASH_RESP_READ_EN
                                    8'h03: state <= S_ADDR;
`endif
                                    default: state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_RDID: begin
                        if (sclk_fall) begin
                            miso_o    <= shift_out[31];
                            miso_oe_o <= 1'b1;
                            shift_out <= {shift_out[30:0], 1'b0};
                        end
                    end
                    S_RDSR: begin
                        if (sclk_fall) begin
                            miso_o    <= shift_out[31];
                            miso_oe_o <= 1'b1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                shift_out <= {STATUS_VAL, 24'h0};
                            end else begin
                                bit_cnt   <= bit_cnt + 5'd1;
                                shift_out <= {shift_out[30:0], 1'b0};
                            end
                        end
                    end
`ifdef SPI_FLASH_RESP_READ_EN
                    S_ADDR: begin
                        if (sclk_rise) begin
                            addr    <= addr_next;
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt   <= '0;
                                shift_out <= {addr_next[7:0] ^ 8'hA5, 24'h0};
                                state     <= S_READ;
                            end
                        end
                    end
                    S_READ: begin
                        if (sclk_fall) begin
                            miso_o    <= shift_out[31];
                            miso_oe_o <= 1'b1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt   <= '0;
                                addr      <= addr_inc;
                                shift_out <= {addr_inc[7:0] ^ 8'hA5, 24'h0};
                            end else begin
                                bit_cnt   <= bit_cnt + 5'd1;
                                shift_out <= {shift_out[30:0], 1'b0};
                            end
                        end
                    end
`endif
                    S_IGNORE: miso_oe_o <= 1'b0;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Simulation and loopback model of an SPI NOR flash target: SPI mode 0 responder sitting on the board-checkout SPI bus (sclk/mosi/cs_b in, miso out).
- Answers RDID (0x9F) with a parameterised 24-bit JEDEC ID and RDSR (0x05) with a status byte, so the PicoBlaze flash-checkout firmware can be exercised without a real part.
- All SPI inputs are oversampled in the clk domain; no logic is clocked by sclk.

Parameters:
- FLASH_ID, 24'h20BA18, JEDEC ID returned by RDID; byte [23:16] is sent first, MSB first.
- STATUS_VAL, 8'h00, byte returned repeatedly by RDSR.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- sclk_i  input  1  SPI clock from master, asynchronous to clk.
- mosi_i  input  1  SPI data from master.
- cs_b_i  input  1  SPI chip select, active low.
- miso_o  output  1  SPI data to master.
- miso_oe_o  output  1  high while miso_o is driven; bus is high-Z otherwise.
- last_cmd_o  output  8  most recent opcode received.
- cmd_strobe_o  output  1  one-clk pulse when an opcode completes.
- busy_o  output  1  high while the responder is selected (state not IDLE).

Behaviour:
- Synchronisers: sclk_i, mosi_i and cs_b_i each pass through 2 flops. The rise/fall edge detect uses a 3rd sclk flop. The master must hold each sclk phase for at least 3 clk.
- Reset values: miso_o=0, miso_oe_o=0, last_cmd_o=0x00, cmd_strobe_o=0, busy_o=0, state=IDLE, all counters and shift registers 0.
- States:
  - IDLE: sync cs_b high. Sync cs_b falling moves to CMD; bit counter cleared.
  - CMD: on each sync sclk rise, shift mosi into the opcode register MSB first.
    - On the 8th rise: last_cmd_o updates and cmd_strobe_o pulses for 1 clk.
    - Opcode 0x9F loads shift_out={FLASH_ID,8'h00} and goes to RDID.
    - Opcode 0x05 loads STATUS_VAL and goes to RDSR.
    - Opcode 0x03 goes to ADDR (only if feature enabled).
    - Any other opcode goes to IGNORE.
  - RDID: on each sync sclk fall, miso_o <= shift_out MSB, then shift left, filling with 0. After 24 bits, bytes read 0x00 until cs_b rises.
  - RDSR: same shifting; STATUS_VAL reloads every 8 bits, repeating indefinitely.
  - IGNORE: miso_oe_o=0; wait for cs_b high.
- Output enable: miso_oe_o=1 in RDID, RDSR and READ from the first sclk fall after the opcode. It is 0 in IDLE, CMD and IGNORE.
- Latency: miso_o updates exactly 3 clk after the raw sclk falling edge (2 sync + 1 register). Opcode is captured 3 clk after the raw 8th rising edge.
- cs_b rising (sync) in any state: next clk goes to IDLE, miso_oe_o=0, partial opcode discarded, last_cmd_o held. A partial opcode (fewer than 8 rises) produces no strobe.
- sclk edges while in IDLE are ignored.
- sclk rise and cs_b rise detected on the same clk: cs_b wins; no shift occurs.
- Synchronous reset during a transaction: immediate return to reset values. The responder stays in IDLE until the next sync cs_b fall.

Optional Feature:
- Macro: SPI_FLASH_RESP_READ_EN.
- Defined: opcode 0x03 goes to ADDR.
  - ADDR captures a 24-bit address MSB first over 24 rises, then enters READ.
  - READ returns data byte = addr[7:0] ^ 8'hA5. The address increments after each byte and wraps 0xFFFFFF to 0x000000.
- Undefined: 0x03 goes to IGNORE (miso_oe_o stays 0); no ADDR/READ logic is synthesised.

Test Plan:
- Reset, then cs_b low, send 0x9F, clock 24 bits -> miso yields 0x20,0xBA,0x18; cmd_strobe_o pulses once; last_cmd_o=0x9F.
- RDID clocked for 40 bits -> bytes 4 and 5 read 0x00; cs_b high -> miso_oe_o=0 and busy_o=0 within 3 clk.
- RDSR with STATUS_VAL=8'h5A, 3 bytes -> 0x5A,0x5A,0x5A.
- Opcode 0xAB -> miso_oe_o stays 0 throughout; last_cmd_o=0xAB; a following 0x9F transaction still returns the ID correctly.
- cs_b raised after 5 opcode bits, then reasserted and 0x9F sent -> no strobe for the aborted frame; ID returned correctly.
- With SPI_FLASH_RESP_READ_EN: 0x03, address 0xFFFFFE, 3 bytes -> 0x5B,0x5A,0xA5 (wrap to 0). Without it: miso_oe_o stays 0 and last_cmd_o=0x03.
